// File: rtl/cache_fill_arbiter_if.sv
// Bus bundle between the fill arbiter, the two cache miss paths and the memory port.
interface cache_fill_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WPB    = 8
);
  localparam int unsigned CNT_W = $clog2(WPB);

  // cache-side requests
  logic              i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;

  // memory port
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;

  // cache fill / completion side
  logic [DATA_W-1:0] fill_data;
  logic [CNT_W-1:0]  fill_word;
  logic              i_fill_we;
  logic              d_fill_we;
  logic              i_tag_we;
  logic              d_tag_we;
  logic              i_done;
  logic              d_done;
  logic              st_ack;
  logic              busy;

  // arbiter side
  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr,
    input  st_req, st_addr, st_data,
    input  mem_rdata_valid, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_data, fill_word, i_fill_we, d_fill_we,
    output i_tag_we, d_tag_we, i_done, d_done, st_ack, busy
  );

  // caches + memory model side
  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr,
    output st_req, st_addr, st_data,
    output mem_rdata_valid, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_data, fill_word, i_fill_we, d_fill_we,
    input  i_tag_we, d_tag_we, i_done, d_done, st_ack, busy
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Shares the memory port between I-miss, D-miss and write-through stores and
// sequences block fills: WPB pipelined reads, data steering, then a tag write.
module cache_fill_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WPB    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_fill_arbiter_if.master bus
);
  localparam int unsigned CNT_W     = $clog2(WPB);
  localparam int unsigned BYTE_W    = $clog2(DATA_W / 8);
  localparam int unsigned BLK_BYTES = WPB * (DATA_W / 8);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BLK_BYTES - 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WPB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t            state;
  state_t            state_nxt;
  owner_t            owner;
  logic [ADDR_W-1:0] blk_addr;    // block-aligned base of the fill in progress
  logic [CNT_W-1:0]  issue_cnt;
  logic              issue_done;  // all WPB reads issued
  logic [CNT_W-1:0]  recv_cnt;
  logic              prio_i;      // I-miss jumps the queue after a D fill starved it

  logic              grant_i;
  logic              grant_d;
  logic              issue_en;
  logic              recv_en;
  logic [ADDR_W-1:0] miss_addr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant decision, read issue, data steering and completion pulses
  always_comb begin
    state_nxt     = state;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    issue_en      = 1'b0;
    recv_en       = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.fill_data = '0;
    bus.fill_word = '0;
    bus.i_fill_we = 1'b0;
    bus.d_fill_we = 1'b0;
    bus.i_tag_we  = 1'b0;
    bus.d_tag_we  = 1'b0;
    bus.i_done    = 1'b0;
    bus.d_done    = 1'b0;
    bus.st_ack    = 1'b0;
    bus.busy      = 1'b0;
    // outputs are forced low while reset is held, even for the IDLE store path
    if (rst_n) begin
      bus.busy = (state != S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (prio_i && bus.i_miss) begin
            grant_i = 1'b1;
          end else if (bus.d_miss) begin
            grant_d = 1'b1;
          end else if (bus.st_req) begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = bus.st_addr;
            bus.mem_wdata = bus.st_data;
            bus.st_ack    = 1'b1;
          end else if (bus.i_miss) begin
            grant_i = 1'b1;
          end
          if (grant_i || grant_d) begin
            state_nxt = S_FILL;
          end
        end
        S_FILL: begin
          if (!issue_done) begin
            issue_en     = 1'b1;
            bus.mem_en   = 1'b1;
            bus.mem_addr = blk_addr | (ADDR_W'(issue_cnt) << BYTE_W);
          end
          if (bus.mem_rdata_valid) begin
            recv_en       = 1'b1;
            bus.fill_data = bus.mem_rdata;
            bus.fill_word = recv_cnt;
            if (owner == OWN_D) begin
              bus.d_fill_we = 1'b1;
            end else begin
              bus.i_fill_we = 1'b1;
            end
            if (recv_cnt == LAST_WORD) begin
              state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (owner == OWN_D) begin
            bus.d_tag_we = 1'b1;
            bus.d_done   = 1'b1;
          end else begin
            bus.i_tag_we = 1'b1;
            bus.i_done   = 1'b1;
          end
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Address of the miss being granted this cycle
  always_comb begin
    miss_addr = grant_d ? bus.d_miss_addr : bus.i_miss_addr;
  end

  // Fill bookkeeping: owner/block latch, issue and receive counters, I priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_I;
      blk_addr   <= '0;
      issue_cnt  <= '0;
      issue_done <= 1'b0;
      recv_cnt   <= '0;
      prio_i     <= 1'b0;
    end else begin
      if (grant_i || grant_d) begin
        owner      <= grant_d ? OWN_D : OWN_I;
        blk_addr   <= miss_addr & ~OFF_MASK;
        issue_cnt  <= '0;
        issue_done <= 1'b0;
        recv_cnt   <= '0;
      end
      if (issue_en) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
        if (issue_cnt == LAST_WORD) begin
          issue_done <= 1'b1;
        end
      end
      if (recv_en) begin
        recv_cnt <= recv_cnt + CNT_W'(1);
      end
      if (state == S_DONE) begin
        prio_i <= (owner == OWN_D) && bus.i_miss;
      end
    end
  end

endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Shares the single off-chip memory port between the I-cache miss path, the D-cache miss path and write-through stores.
- On a granted miss, sequences an 8-word block fill: issues 8 pipelined reads, then steers the returning words into the requesting cache's data array, then writes that cache's tag.
- Sits between both caches and the memory model. The pipeline stalls on the done handshakes.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, memory word width
WPB, 8, words per cache block (16-byte block); counters are log2(WPB) bits

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_miss  in  1  I-cache miss; held high until i_done
i_miss_addr  in  ADDR_W  I-cache miss byte address
d_miss  in  1  D-cache miss; held high until d_done
d_miss_addr  in  ADDR_W  D-cache miss byte address
st_req  in  1  write-through store request
st_addr  in  ADDR_W  store byte address
st_data  in  DATA_W  store data
mem_en  out  1  memory access enable
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
mem_rdata_valid  in  1  read data valid from memory
mem_rdata  in  DATA_W  read data
fill_data  out  DATA_W  word to write into the cache data array
fill_word  out  3  word index within the block
i_fill_we  out  1  I-cache data array write enable
d_fill_we  out  1  D-cache data array write enable
i_tag_we  out  1  I-cache tag/valid write, one-cycle pulse
d_tag_we  out  1  D-cache tag/valid write, one-cycle pulse
i_done  out  1  I fill complete, one-cycle pulse
d_done  out  1  D fill complete, one-cycle pulse
st_ack  out  1  store accepted this cycle
busy  out  1  state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters=0; owner=I; prio_i=0.
  - All outputs are 0, including mem_addr, mem_wdata, fill_data and fill_word.
- States: IDLE, FILL, DONE.

IDLE (grant decision, combinational on current inputs):
- Priority: d_miss > st_req > i_miss.
- Exception: if prio_i=1 and i_miss=1, i_miss wins over d_miss and st_req.
- Miss grant: latch blk = addr[15:4] and owner (I or D); clear issue_cnt and recv_cnt; go to FILL next cycle. No memory access happens in the grant cycle.
- Store grant (same cycle, state stays IDLE):
  - mem_en=1, mem_wr=1, mem_addr=st_addr, mem_wdata=st_data, st_ack=1.
  - Back-to-back stores are accepted every cycle.
- mem_rdata_valid is ignored in IDLE and in DONE. Stale returns after a reset must not write either cache.

FILL:
- Read issue: while issue_cnt < 8, drive mem_en=1, mem_wr=0, mem_addr={blk, issue_cnt, 1'b0}; issue_cnt increments each cycle. Eight consecutive issue cycles, no bubbles.
- Data return: each cycle mem_rdata_valid=1 drives fill_data=mem_rdata, fill_word=recv_cnt, and owner's *_fill_we=1 (combinational); recv_cnt increments.
- Ordering: memory returns data in issue order. The block does not count latency; it relies only on mem_rdata_valid.
- Exit: the valid with recv_cnt=7 moves state to DONE.
- Stores are not accepted during FILL or DONE: st_ack=0, and the requester holds st_req.
- Dropped requests: if the owner's miss deasserts mid-fill, the fill still completes.

DONE (one cycle):
- Owner's *_tag_we=1 and *_done=1.
- prio_i is set to 1 if owner=D and i_miss=1; otherwise prio_i is cleared to 0.
- Return to IDLE next cycle. A new grant can occur in that IDLE cycle.

Timing and corner cases:
- Fill timing with memory latency L (data valid L cycles after issue), grant in cycle T:
  - Issues in T+1..T+8.
  - Data in T+1+L..T+8+L.
  - DONE in T+9+L.
- Reset mid-FILL: immediate return to IDLE. No done or tag pulse is generated. The requester re-requests.
- Requests arriving in the same cycle as reset release are evaluated on the first clock edge after rst_n rises.

Test Plan:
1. Reset, then i_miss=1 with i_miss_addr=0x1236, memory L=4 returning word k = 0xA000+k:
   - mem_addr sequence 0x1230, 0x1232, …, 0x123E.
   - i_fill_we asserted 8 times with fill_word 0..7 and data 0xA000..0xA007.
   - i_tag_we and i_done pulse 13 cycles after grant; d_fill_we never asserts.
2. d_miss(0x4000) and i_miss(0x0010) raised in the same cycle:
   - D block filled first.
   - In the d_done cycle prio_i is set.
   - Next IDLE grants I even though d_miss(0x5000) is raised again; D is served after i_done.
3. st_req with st_addr=0x2002, st_data=0xBEEF while IDLE:
   - Same cycle: mem_en=1, mem_wr=1, st_ack=1; state stays IDLE.
   - Same stimulus during FILL: st_ack=0 until the first IDLE cycle, then the write is issued.
4. Drop rst_n at the 3rd data return of a D fill:
   - All outputs go to 0 immediately and busy=0.
   - The 5 remaining mem_rdata_valid pulses cause no *_fill_we; d_done never pulses.
5. Spurious mem_rdata_valid in IDLE → no fill writes and no state change.
   - The owner's miss deasserted mid-fill → fill still completes, tag_we/done still pulse.
6. d_miss and st_req together in IDLE:
   - d_miss is granted, st_ack=0.
   - The store is acked in the IDLE cycle right after d_done.
